fc_addrgen_multi: RTL and testbench

- Parametrised successor to the two-port FC input-neuron address generator.
- Produces NUM_PORTS interleaved input-buffer read addresses per beat, plus a linear weight-ROM address.
- Sweeps all output-neuron groups for one FC layer per start/done transaction; supports stall via enable.
- Sits between the FC layer controller and the input-neuron/weight memories, feeding the PI-wide MAC array.

---
 rtl/fc_addrgen_multi_pkg.sv | 27 ++
 rtl/fc_addrgen_multi_wrap_counter.sv | 26 ++
 rtl/fc_addrgen_multi.sv | 160 ++++++++++++++++
 tb/tb_fc_addrgen_multi.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_addrgen_multi_pkg.sv
// Shared state encoding, default layer shape and sizing helpers for the FC address generator.
// FC_ADDRGEN_BIAS_EN adds the per-group bias state.
package fc_addrgen_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef FC_ADDRGEN_BIAS_EN
        , ST_BIAS = 2'd2
`endif
    } state_t;

    localparam int DEF_INNEURON  = 576;
    localparam int DEF_OUTNEURON = 10;
    localparam int DEF_PI        = 16;
    localparam int DEF_PO        = 1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Bits needed to hold values 0..range-1, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/fc_addrgen_multi_wrap_counter.sv
// Counter over 0..MAX with clear; wrap flags the increment that returns it to zero.
module fc_wrap_counter
    import fc_addrgen_multi_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = cnt_width(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = inc && (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fc_addrgen_multi.sv
// Multi-port FC input-buffer / weight-ROM address generator sweeping every output group per start.
// Define FC_ADDRGEN_BIAS_EN to insert one bias beat after each group.
module fc_addrgen_multi
    import fc_addrgen_multi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WADDR_WIDTH = 12,
    parameter int INNEURON    = DEF_INNEURON,
    parameter int OUTNEURON   = DEF_OUTNEURON,
    parameter int PI          = DEF_PI,
    parameter int PO          = DEF_PO,
    parameter int NUM_PORTS   = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          enable,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0]               addr,
    output logic [WADDR_WIDTH-1:0]                        waddr,
    output logic                                          addr_valid,
    output logic                                          acc_last,
    output logic                                          done,
    output logic                                          busy,
`ifdef FC_ADDRGEN_BIAS_EN
    output logic                                          bias_valid,
    output logic [cnt_width(ceil_div(OUTNEURON, PO))-1:0] bias_addr,
`endif
    output state_t                                        dbg_state,
    output logic [cnt_width(ceil_div(OUTNEURON, PO))-1:0] dbg_group
);

    localparam int IN_WORDS = INNEURON / PI;
    localparam int BEATS    = IN_WORDS / NUM_PORTS;
    localparam int GROUPS   = ceil_div(OUTNEURON, PO);
    localparam int TOTAL    = GROUPS * BEATS;
    localparam int BEAT_W   = cnt_width(BEATS);
    localparam int GRP_W    = cnt_width(GROUPS);
    localparam int WCNT_W   = cnt_width(TOTAL);

    if (IN_WORDS % NUM_PORTS != 0) begin : g_bad_ports
        $error("IN_WORDS must be a multiple of NUM_PORTS");
    end
    if (64'(IN_WORDS) > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("input-buffer addresses do not fit ADDR_WIDTH");
    end
    if (64'(TOTAL) > (64'd1 << WADDR_WIDTH)) begin : g_bad_waddr
        $error("weight addresses do not fit WADDR_WIDTH");
    end

    state_t                          state;
    logic [BEAT_W-1:0]               beat_cnt;
    logic [GRP_W-1:0]                grp_cnt;
    logic [WCNT_W-1:0]               waddr_cnt;
    logic                            beat_wrap;
    logic                            grp_wrap;
    logic                            grp_inc;
    logic                            issue;
    logic                            clr;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_next;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_rst;

    assign issue = (state == ST_RUN) && enable;
    assign clr   = (state == ST_IDLE) && start;

`ifdef FC_ADDRGEN_BIAS_EN
    // The group only advances once its bias beat has gone out.
    assign grp_inc = (state == ST_BIAS) && enable;
`else
    assign grp_inc = beat_wrap;
`endif

    fc_wrap_counter #(.MAX(BEATS - 1), .W(BEAT_W)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (issue),
        .clr   (clr),
        .cnt   (beat_cnt),
        .wrap  (beat_wrap)
    );

    fc_wrap_counter #(.MAX(GROUPS - 1), .W(GRP_W)) u_grp_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (grp_inc),
        .clr   (clr),
        .cnt   (grp_cnt),
        .wrap  (grp_wrap)
    );

    always_comb begin
        addr_next = '0;
        addr_rst  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            addr_next[k*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(32'(beat_cnt) * NUM_PORTS + k);
            addr_rst[k*ADDR_WIDTH +: ADDR_WIDTH]  = ADDR_WIDTH'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            waddr_cnt  <= '0;
            addr       <= addr_rst;
            waddr      <= '0;
            addr_valid <= 1'b0;
            acc_last   <= 1'b0;
            done       <= 1'b0;
`ifdef FC_ADDRGEN_BIAS_EN
            bias_valid <= 1'b0;
            bias_addr  <= '0;
`endif
        end else begin
            addr_valid <= 1'b0;
            acc_last   <= 1'b0;
            done       <= 1'b0;
`ifdef FC_ADDRGEN_BIAS_EN
            bias_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        waddr_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        addr       <= addr_next;
                        waddr      <= WADDR_WIDTH'(waddr_cnt);
                        waddr_cnt  <= waddr_cnt + 1'b1;
                        addr_valid <= 1'b1;
                        acc_last   <= beat_wrap;
`ifdef FC_ADDRGEN_BIAS_EN
                        if (beat_wrap) state <= ST_BIAS;
`else
                        done <= grp_wrap;
                        if (grp_wrap) state <= ST_IDLE;
`endif
                    end
                end
`ifdef FC_ADDRGEN_BIAS_EN
                ST_BIAS: begin
                    if (enable) begin
                        bias_valid <= 1'b1;
                        bias_addr  <= grp_cnt;
                        done       <= grp_wrap;
                        state      <= grp_wrap ? ST_IDLE : ST_RUN;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign dbg_group = grp_cnt;

endmodule

// File: tb/tb_fc_addrgen_multi.sv
// Scoreboard bench for fc_addrgen_multi: default 2-port instance plus a 4-port, 3-group instance.
// Build with FC_ADDRGEN_BIAS_EN to cover the bias-beat variant.
module tb_fc_addrgen_multi;
    import fc_addrgen_multi_pkg::*;

    localparam int AW       = 12;
    localparam int WAW      = 12;
    localparam int A_BEATS  = 18;
    localparam int A_GROUPS = 10;
    localparam int B_BEATS  = 8;
    localparam int B_GROUPS = 3;
`ifdef FC_ADDRGEN_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    localparam int A_ISSUED = A_GROUPS * (A_BEATS + BIAS);
    localparam int B_ISSUED = B_GROUPS * (B_BEATS + BIAS);
    localparam int EW       = 1 + 8 + 4*AW + WAW + 2;
    // Bias beats are checked on flag, group index, acc_last and done only.
    localparam logic [EW-1:0] BIAS_MASK = {1'b1, 8'hFF, {(4*AW){1'b0}}, {WAW{1'b0}}, 2'b11};

    logic clk = 1'b0;
    logic reset;
    logic start_a, enable_a, start_b, enable_b;

    logic [2*AW-1:0] addr_a;
    logic [WAW-1:0]  waddr_a;
    logic            addr_valid_a, acc_last_a, done_a, busy_a, bias_valid_a;
    logic [3:0]      bias_addr_a, dbg_group_a;
    state_t          dbg_state_a;

    logic [4*AW-1:0] addr_b;
    logic [WAW-1:0]  waddr_b;
    logic            addr_valid_b, acc_last_b, done_b, busy_b, bias_valid_b;
    logic [1:0]      bias_addr_b, dbg_group_b;
    state_t          dbg_state_b;

    logic [EW-1:0] exp_qa[$];
    logic [EW-1:0] exp_qb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats_a = 0, dones_a = 0, first_a = -1, last_a = -1, start_cyc_a = 0;
    int beats_b = 0, dones_b = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    fc_addrgen_multi u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .enable     (enable_a),
        .addr       (addr_a),
        .waddr      (waddr_a),
        .addr_valid (addr_valid_a),
        .acc_last   (acc_last_a),
        .done       (done_a),
        .busy       (busy_a),
`ifdef FC_ADDRGEN_BIAS_EN
        .bias_valid (bias_valid_a),
        .bias_addr  (bias_addr_a),
`endif
        .dbg_state  (dbg_state_a),
        .dbg_group  (dbg_group_a)
    );

    fc_addrgen_multi #(
        .INNEURON  (256),
        .OUTNEURON (3),
        .PI        (8),
        .NUM_PORTS (4)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .enable     (enable_b),
        .addr       (addr_b),
        .waddr      (waddr_b),
        .addr_valid (addr_valid_b),
        .acc_last   (acc_last_b),
        .done       (done_b),
        .busy       (busy_b),
`ifdef FC_ADDRGEN_BIAS_EN
        .bias_valid (bias_valid_b),
        .bias_addr  (bias_addr_b),
`endif
        .dbg_state  (dbg_state_b),
        .dbg_group  (dbg_group_b)
    );

`ifndef FC_ADDRGEN_BIAS_EN
    assign bias_valid_a = 1'b0;
    assign bias_addr_a  = '0;
    assign bias_valid_b = 1'b0;
    assign bias_addr_b  = '0;
`endif

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk(input logic b, input int baddr, input logic [4*AW-1:0] a,
                                         input int wa, input logic al, input logic dn);
        return {b, 8'(baddr), a, WAW'(wa), al, dn};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected sweep: every addr beat, then (bias build) one bias beat per group.
    task automatic push_sweep(input int sel, input int ports, input int beats, input int groups);
        logic [4*AW-1:0] a;
        logic [EW-1:0]   e;
        for (int g = 0; g < groups; g++) begin
            for (int b = 0; b < beats; b++) begin
                a = '0;
                for (int k = 0; k < ports; k++) a[k*AW +: AW] = AW'(b*ports + k);
                e = mk(1'b0, 0, a, g*beats + b, b == beats-1,
                       BIAS == 0 && b == beats-1 && g == groups-1);
                if (sel == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
            end
            if (BIAS != 0) begin
                e = mk(1'b1, g, '0, 0, 1'b0, g == groups-1);
                if (sel == 0) exp_qa.push_back(e); else exp_qb.push_back(e);
            end
        end
    endtask

    task automatic wait_beats(input int sel, input int n, input int budget);
        int left = budget;
        while (((sel == 0) ? beats_a : beats_b) < n && left > 0) begin
            @(negedge clk);
            #1;
            left--;
        end
        check("wait_beats_timeout", 64'(((sel == 0) ? beats_a : beats_b) >= n), 64'd1);
    endtask

    task automatic begin_sweep_a();
        beats_a = 0; dones_a = 0; first_a = -1; last_a = -1;
        push_sweep(0, 2, A_BEATS, A_GROUPS);
        start_cyc_a = cyc;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic finish_sweep_a(input string tag, input int span);
        wait_beats(0, A_ISSUED, 600);
        tick(3);
        check({tag, "_beats"}, 64'(beats_a), 64'(A_ISSUED));
        check({tag, "_dones"}, 64'(dones_a), 64'd1);
        check({tag, "_latency"}, 64'(first_a - start_cyc_a), 64'd2);
        check({tag, "_span"}, 64'(last_a - first_a), 64'(span));
        check({tag, "_busy"}, 64'(busy_a), 64'd0);
        check({tag, "_idle"}, 64'(dbg_state_a), 64'(ST_IDLE));
        check({tag, "_q_left"}, 64'(exp_qa.size()), 64'd0);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_addr"}, 64'(addr_a), 64'h001000);
        check({tag, "_waddr"}, 64'(waddr_a), 64'd0);
        check({tag, "_valid"}, 64'({addr_valid_a, acc_last_a, done_a, bias_valid_a}), 64'd0);
        check({tag, "_busy"}, 64'(busy_a), 64'd0);
        check({tag, "_group"}, 64'(dbg_group_a), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check_beat(input int sel, input logic [EW-1:0] got, input logic dual);
        logic [EW-1:0] exp;
        logic [EW-1:0] mask;
        check((sel == 0) ? "a_dual_valid" : "b_dual_valid", 64'(dual), 64'd0);
        n_checks++;
        if (((sel == 0) ? exp_qa.size() : exp_qb.size()) == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected_beat: got %0h expected none", (sel == 0) ? "a" : "b", got);
        end else begin
            exp  = (sel == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
            mask = exp[EW-1] ? BIAS_MASK : '1;
            if ((got & mask) !== (exp & mask)) begin
                n_fail++;
                $display("FAIL %s_beat: got %0h expected %0h", (sel == 0) ? "a" : "b",
                         got & mask, exp & mask);
            end
        end
    endtask

    always @(negedge clk) begin
        if (addr_valid_a || bias_valid_a) begin
            check_beat(0, mk(bias_valid_a, int'(bias_addr_a), {24'b0, addr_a}, int'(waddr_a),
                             acc_last_a, done_a), addr_valid_a && bias_valid_a);
            beats_a++;
            if (done_a) dones_a++;
            if (first_a < 0) first_a = cyc;
            last_a = cyc;
        end else if (!reset) begin
            check("a_idle_flags", 64'({done_a, acc_last_a}), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (addr_valid_b || bias_valid_b) begin
            check_beat(1, mk(bias_valid_b, int'(bias_addr_b), addr_b, int'(waddr_b),
                             acc_last_b, done_b), addr_valid_b && bias_valid_b);
            beats_b++;
            if (done_b) dones_b++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start_a = 1'b0; enable_a = 1'b1; start_b = 1'b0; enable_b = 1'b1;
        tick(3);
        check_reset_a("rst");
        check("rst_b_addr", 64'(addr_b), 64'h003002001000);
        reset = 1'b0;
        tick(2);

        // Full sweep with enable held high.
        begin_sweep_a();
        finish_sweep_a("sweep", A_ISSUED - 1);

        // Three-cycle stall right after beat 5.
        begin_sweep_a();
        wait_beats(0, 6, 50);
        enable_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", 64'(addr_valid_a), 64'd0);
            check("stall_addr", 64'(addr_a), 64'h00B00A);
            check("stall_waddr", 64'(waddr_a), 64'd5);
        end
        enable_a = 1'b1;
        finish_sweep_a("stall", A_ISSUED - 1 + 3);

        // Reset in the middle of a sweep aborts it without a done pulse.
        begin_sweep_a();
        wait_beats(0, 51, 100);
        reset = 1'b1;
        exp_qa.delete();
        @(negedge clk);
        #1;
        check_reset_a("abort");
        check("abort_no_done", 64'(dones_a), 64'd0);
        reset = 1'b0;
        tick(2);
        begin_sweep_a();
        finish_sweep_a("after_abort", A_ISSUED - 1);

        // start while busy and during the final issuing cycle is ignored.
        begin_sweep_a();
        wait_beats(0, 21, 50);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        wait_beats(0, A_ISSUED - 1, 600);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        finish_sweep_a("ignore_start", A_ISSUED - 1);

        // Four-port, three-group configuration.
        beats_b = 0; dones_b = 0;
        push_sweep(1, 4, B_BEATS, B_GROUPS);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        wait_beats(1, B_ISSUED, 200);
        tick(3);
        check("b_beats", 64'(beats_b), 64'(B_ISSUED));
        check("b_dones", 64'(dones_b), 64'd1);
        check("b_busy", 64'(busy_b), 64'd0);
        check("b_q_left", 64'(exp_qb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
